aes_sipo_ctrl: RTL and testbench
================================

Name: aes_sipo_ctrl

Overview:
Sequencer for the AES key and block SIPO register banks and the AES core. It accepts one command, then streams 32-bit key words into the key SIPO and block words into the block SIPO. It pulses the AES core start, waits for done, and streams result words back out. It sits between the host word interface (valid/ready) and the AES core with its two SIPO input banks.

Parameters:
R_DATA_WIDTH, 32, width of one word and of each SIPO slot
N_KEY_REG, 8, key SIPO depth in words (max key 256 bits)
N_BLK_REG, 4, block SIPO depth in words (128-bit AES block)
KEY_ADDR_BITS, $clog2(N_KEY_REG), key SIPO address width
BLK_ADDR_BITS, $clog2(N_BLK_REG), block SIPO and result word index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both high
cmd_new_key  in  1  1 = reload key before block; 0 = reuse loaded key
cmd_key_len  in  2  0 = 128 (4 words), 1 = 192 (6), 2 = 256 (8), 3 = illegal
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when both high
s_data  in  R_DATA_WIDTH  input word
key_load  out  1  key SIPO load strobe
key_addr  out  KEY_ADDR_BITS  key SIPO slot
blk_load  out  1  block SIPO load strobe
blk_addr  out  BLK_ADDR_BITS  block SIPO slot
sipo_din  out  R_DATA_WIDTH  data to both SIPOs (equals s_data)
key_len_o  out  2  registered key length to AES core
aes_start  out  1  one-cycle start pulse
aes_done  in  1  AES core completion pulse
res_in  in  R_DATA_WIDTH*N_BLK_REG  AES result block
m_valid  out  1  output word valid
m_ready  in  1  output word consumed when both high
m_data  out  R_DATA_WIDTH  output word
key_loaded  out  1  key bank holds a complete key
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on illegal command

Behaviour:
- Reset values: state IDLE, cnt 0, key_loaded 0, key_len_o 0, err 0, aes_start 0. Strobes, valid and ready outputs are 0 except cmd_ready=1. Reset mid-operation aborts without a done response; SIPO contents are don't-care.
- States: IDLE, LOAD_KEY, LOAD_BLK, START, WAIT, OUT.
- IDLE, cmd_ready=1. On cmd_valid:
  - cmd_key_len==3: err pulses next cycle; stay IDLE; key_loaded unchanged.
  - cmd_new_key or !key_loaded: latch cmd_key_len into key_len_o, clear key_loaded, cnt=0, go to LOAD_KEY.
  - Otherwise: cnt=0, go to LOAD_BLK.
- LOAD_KEY: s_ready=1.
  - key_load = s_valid & s_ready, combinational, same cycle; key_addr=cnt; sipo_din=s_data.
  - Word i goes to slot i (word 0 = key LSBs).
  - On the accept of word nwords-1 (3/5/7): set key_loaded, cnt=0, go to LOAD_BLK.
  - Unused key slots are not written.
- LOAD_BLK: same handshake to the block bank, blk_addr=cnt. On the accept of word N_BLK_REG-1, go to START.
- START: aes_start=1 for exactly one cycle, the cycle after the last block word is accepted; then go to WAIT.
- WAIT: hold, no timeout. On aes_done: cnt=0, go to OUT. aes_done in any other state is ignored.
- OUT:
  - m_valid=1 and m_data = res_in[cnt*R_DATA_WIDTH +: R_DATA_WIDTH], sampled live.
  - On m_valid & m_ready, cnt++.
  - On the last word, go to IDLE; cmd_ready returns the next cycle.
  - m_data is held stable while m_ready is low.
- s_ready=0 outside the LOAD states; s_valid there is ignored and never loaded.
- cmd_ready=0 outside IDLE.
- cnt is the wider of KEY_ADDR_BITS and BLK_ADDR_BITS and never wraps; the last-word compare ends each phase.
- Zero-bubble rule: back-to-back s_valid gives one word per cycle across the LOAD_KEY→LOAD_BLK boundary.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state encoding localparams;
  - KEY_LEN_128/192/256/ILLEGAL codes;
  - a key-length→word-count function (4/6/8).
- One natural sub-module: the existing sipo, instantiated twice by the parent (not inside this block).
- The controller itself is a single FSM plus counter; no further sub-modules.

Test Plan:
- cmd new_key=1, len=0; key words 0x00010203..0x0C0D0E0F, block words 0xA0..0xA3 back-to-back → key_load at addr 0..3, blk_load at addr 0..3, aes_start one cycle after 0xA3; aes_done with res_in=0xDDCCBBAA_… → m_data 0x…AA word 0 first, 4 words, then cmd_ready=1.
- len=2 (256) → 8 key_load strobes at addr 0..7 with no gaps, then blk phase; key_len_o=2.
- Second cmd new_key=0 after a completed op → no key_load, direct LOAD_BLK; key_loaded stays 1.
- cmd_key_len=3 → err high for one cycle, no strobes, state IDLE; a following valid cmd proceeds normally.
- Random s_valid and m_ready gaps (50%) → strobes only on handshake cycles, m_data stable while stalled, word counts exact.
- rst asserted in LOAD_KEY after 2 words, then cmd new_key=0 → key_loaded=0 forces a full key reload (LOAD_KEY entered).

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES SIPO sequencer: state encoding,
// key-length codes and the key-length to key-word-count mapping.
package aes_ctrl_pkg;

    localparam int STATE_BITS = 3;
    typedef logic [STATE_BITS-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD_KEY = 3'd1;
    localparam state_t ST_LOAD_BLK = 3'd2;
    localparam state_t ST_START    = 3'd3;
    localparam state_t ST_WAIT     = 3'd4;
    localparam state_t ST_OUT      = 3'd5;

    localparam logic [1:0] KEY_LEN_128     = 2'd0;
    localparam logic [1:0] KEY_LEN_192     = 2'd1;
    localparam logic [1:0] KEY_LEN_256     = 2'd2;
    localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

    // Number of 32-bit key words for a key-length code; 0 for the illegal code.
    function automatic logic [3:0] key_words(input logic [1:0] len);
        logic [3:0] n;
        case (len)
            KEY_LEN_128: n = 4'd4;
            KEY_LEN_192: n = 4'd6;
            KEY_LEN_256: n = 4'd8;
            default:     n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/aes_sipo_ctrl.sv
// Sequencer between the host word interface and the AES core. Accepts one
// command, streams key words (when needed) and block words into the two SIPO
// banks, pulses the core start, waits for done and streams the result words.
module aes_sipo_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int R_DATA_WIDTH  = 32,
    parameter int N_KEY_REG     = 8,
    parameter int N_BLK_REG     = 4,
    parameter int KEY_ADDR_BITS = $clog2(N_KEY_REG),
    parameter int BLK_ADDR_BITS = $clog2(N_BLK_REG)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_new_key,
    input  logic [1:0]                        cmd_key_len,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [R_DATA_WIDTH-1:0]           s_data,
    output logic                              key_load,
    output logic [KEY_ADDR_BITS-1:0]          key_addr,
    output logic                              blk_load,
    output logic [BLK_ADDR_BITS-1:0]          blk_addr,
    output logic [R_DATA_WIDTH-1:0]           sipo_din,
    output logic [1:0]                        key_len_o,
    output logic                              aes_start,
    input  logic                              aes_done,
    input  logic [R_DATA_WIDTH*N_BLK_REG-1:0] res_in,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [R_DATA_WIDTH-1:0]           m_data,
    output logic                              key_loaded,
    output logic                              busy,
    output logic                              err
);

    // One counter serves key slots, block slots and result words.
    localparam int CNT_BITS = (KEY_ADDR_BITS > BLK_ADDR_BITS) ? KEY_ADDR_BITS : BLK_ADDR_BITS;
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] BLK_LAST = CNT_BITS'(N_BLK_REG - 1);

    state_t                state_r;
    state_t                state_s;
    logic [CNT_BITS-1:0]   cnt_r;
    logic [CNT_BITS-1:0]   cnt_s;
    logic                  key_loaded_r;
    logic                  key_loaded_s;
    logic [1:0]            key_len_r;
    logic [1:0]            key_len_s;
    logic                  err_r;
    logic                  err_s;
    logic [3:0]            key_last_idx_s;
    logic                  key_last_s;
    logic                  blk_last_s;
    logic [BLK_ADDR_BITS-1:0] blk_idx_s;

    assign key_last_idx_s = key_words(key_len_r) - 4'd1;
    assign key_last_s     = (32'(cnt_r) == 32'(key_last_idx_s));
    assign blk_last_s     = (cnt_r == BLK_LAST);
    assign blk_idx_s      = cnt_r[BLK_ADDR_BITS-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counter, key status, latched key length and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= CNT_ZERO;
            key_loaded_r <= 1'b0;
            key_len_r    <= 2'd0;
            err_r        <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            key_loaded_r <= key_loaded_s;
            key_len_r    <= key_len_s;
            err_r        <= err_s;
        end
    end

    // Next-state and next-datapath decisions; the last-word compare ends each phase.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        key_loaded_s = key_loaded_r;
        key_len_s    = key_len_r;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_key_len == KEY_LEN_ILLEGAL) begin
                        err_s = 1'b1;
                    end else if (cmd_new_key || !key_loaded_r) begin
                        key_len_s    = cmd_key_len;
                        key_loaded_s = 1'b0;
                        cnt_s        = CNT_ZERO;
                        state_s      = ST_LOAD_KEY;
                    end else begin
                        cnt_s   = CNT_ZERO;
                        state_s = ST_LOAD_BLK;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_KEY: begin
                if (s_valid) begin
                    if (key_last_s) begin
                        key_loaded_s = 1'b1;
                        cnt_s        = CNT_ZERO;
                        state_s      = ST_LOAD_BLK;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_LOAD_KEY;
                end
            end
            ST_LOAD_BLK: begin
                if (s_valid) begin
                    if (blk_last_s) begin
                        state_s = ST_START;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_LOAD_BLK;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes_done) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    if (blk_last_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: handshakes and load strobes follow the current state.
    always_comb begin
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        key_load   = 1'b0;
        blk_load   = 1'b0;
        aes_start  = 1'b0;
        m_valid    = 1'b0;
        m_data     = {R_DATA_WIDTH{1'b0}};
        key_addr   = cnt_r[KEY_ADDR_BITS-1:0];
        blk_addr   = blk_idx_s;
        sipo_din   = s_data;
        key_len_o  = key_len_r;
        key_loaded = key_loaded_r;
        err        = err_r;
        busy       = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_LOAD_KEY: begin
                s_ready  = 1'b1;
                key_load = s_valid;
            end
            ST_LOAD_BLK: begin
                s_ready  = 1'b1;
                blk_load = s_valid;
            end
            ST_START: begin
                aes_start = 1'b1;
            end
            ST_WAIT: begin
                aes_start = 1'b0;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                m_data  = res_in[int'(blk_idx_s)*R_DATA_WIDTH +: R_DATA_WIDTH];
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_sipo_ctrl.sv
// Self-checking bench for aes_sipo_ctrl: a transaction-level model (expected
// write/output queues built from each command) is compared against the DUT on
// every cycle, plus literal checks after each directed scenario.
module tb_aes_sipo_ctrl;

    localparam int W  = 32;
    localparam int NK = 8;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_new_key;
    logic [1:0]      cmd_key_len;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            key_load;
    logic [2:0]      key_addr;
    logic            blk_load;
    logic [1:0]      blk_addr;
    logic [W-1:0]    sipo_din;
    logic [1:0]      key_len_o;
    logic            aes_start;
    logic            aes_done;
    logic [W*NB-1:0] res_in;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_data;
    logic            key_loaded;
    logic            busy;
    logic            err;

    aes_sipo_ctrl #(.R_DATA_WIDTH(W), .N_KEY_REG(NK), .N_BLK_REG(NB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_new_key(cmd_new_key), .cmd_key_len(cmd_key_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .key_load(key_load), .key_addr(key_addr),
        .blk_load(blk_load), .blk_addr(blk_addr),
        .sipo_din(sipo_din), .key_len_o(key_len_o),
        .aes_start(aes_start), .aes_done(aes_done), .res_in(res_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .key_loaded(key_loaded), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stimulus data shared with the model.
    logic [31:0] cur_key [8];
    logic [31:0] cur_blk [4];
    logic [31:0] stream_q [$];

    // Model state.
    bit          m_on = 1'b0;
    bit          m_idle, m_key_loaded, m_err, m_start, m_wait;
    logic [1:0]  m_key_len;
    int          q_key_addr [$];
    logic [31:0] q_key_data [$];
    int          q_blk_addr [$];
    logic [31:0] q_blk_data [$];
    logic [31:0] q_out [$];

    // Observation log for literal checks.
    int          cyc = 0;
    int          n_key_loads, n_blk_loads, n_starts, n_errs;
    int          last_key_addr, last_blk_cyc, start_cyc, first_load_cyc;
    bit          first_seen;
    logic [31:0] out_log [$];

    function automatic int nwords(input logic [1:0] len);
        return (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    endfunction

    task automatic clear_log();
        n_key_loads = 0; n_blk_loads = 0; n_starts = 0; n_errs = 0;
        last_key_addr = -1; last_blk_cyc = 0; start_cyc = 0;
        first_load_cyc = 0; first_seen = 1'b0;
        out_log.delete();
    endtask

    // Compare process: checks outputs against the model, then advances the
    // model by the handshakes that complete on the coming rising edge.
    always @(negedge clk) begin
        bit e_key, e_blk, e_out, e_sr;
        cyc++;
        if (rst) begin
            m_on = 1'b1; m_idle = 1'b1; m_key_loaded = 1'b0; m_err = 1'b0;
            m_start = 1'b0; m_wait = 1'b0; m_key_len = 2'd0;
            q_key_addr.delete(); q_key_data.delete();
            q_blk_addr.delete(); q_blk_data.delete(); q_out.delete();
        end else if (m_on) begin
            e_sr  = (q_key_addr.size() > 0) || (q_blk_addr.size() > 0);
            e_key = s_valid && (q_key_addr.size() > 0);
            e_blk = s_valid && (q_key_addr.size() == 0) && (q_blk_addr.size() > 0);
            e_out = (q_out.size() > 0);
            check("cmd_ready", cmd_ready, m_idle);
            check("busy", busy, !m_idle);
            check("s_ready", s_ready, e_sr);
            check("key_load", key_load, e_key);
            check("blk_load", blk_load, e_blk);
            check("aes_start", aes_start, m_start);
            check("m_valid", m_valid, e_out);
            check("key_loaded", key_loaded, m_key_loaded);
            check("key_len_o", key_len_o, m_key_len);
            check("err", err, m_err);
            if (e_key) begin
                check("key_addr", key_addr, q_key_addr[0]);
                check("key_data", sipo_din, q_key_data[0]);
            end
            if (e_blk) begin
                check("blk_addr", blk_addr, q_blk_addr[0]);
                check("blk_data", sipo_din, q_blk_data[0]);
            end
            if (e_out) begin
                check("m_data", m_data, q_out[0]);
            end

            if (key_load) begin n_key_loads++; last_key_addr = key_addr; end
            if (blk_load) begin n_blk_loads++; last_blk_cyc = cyc; end
            if ((key_load || blk_load) && !first_seen) begin
                first_seen = 1'b1; first_load_cyc = cyc;
            end
            if (aes_start) begin n_starts++; start_cyc = cyc; end
            if (m_valid && m_ready) out_log.push_back(m_data);
            if (err) n_errs++;

            m_err = 1'b0;
            if (m_wait && aes_done) begin
                m_wait = 1'b0;
                for (int i = 0; i < NB; i++) q_out.push_back(res_in[i*W +: W]);
            end
            if (m_start) begin m_start = 1'b0; m_wait = 1'b1; end
            if (m_idle && cmd_valid) begin
                if (cmd_key_len == 2'd3) begin
                    m_err = 1'b1;
                end else begin
                    if (cmd_new_key || !m_key_loaded) begin
                        m_key_loaded = 1'b0;
                        m_key_len    = cmd_key_len;
                        for (int i = 0; i < nwords(cmd_key_len); i++) begin
                            q_key_addr.push_back(i); q_key_data.push_back(cur_key[i]);
                        end
                    end
                    for (int i = 0; i < NB; i++) begin
                        q_blk_addr.push_back(i); q_blk_data.push_back(cur_blk[i]);
                    end
                    m_idle = 1'b0;
                end
            end
            if (e_key) begin
                void'(q_key_addr.pop_front()); void'(q_key_data.pop_front());
                if (q_key_addr.size() == 0) m_key_loaded = 1'b1;
            end else if (e_blk) begin
                void'(q_blk_addr.pop_front()); void'(q_blk_data.pop_front());
                if (q_blk_addr.size() == 0) m_start = 1'b1;
            end
            if (e_out && m_ready) begin
                void'(q_out.pop_front());
                if (q_out.size() == 0) m_idle = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit nk, input logic [1:0] len);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_new_key = nk; cmd_key_len = len;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); ok = cmd_ready; tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input bit gaps);
        bit ok;
        while (stream_q.size() > 0) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0; tick();
            end
            s_valid = 1'b1;
            s_data  = stream_q.pop_front();
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk); ok = s_ready; tick();
            end
            if (!ok) check("s_ready_timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic run_op(input bit nk, input logic [1:0] len, input bit send_key,
                          input bit gaps, input logic [W*NB-1:0] res);
        bit ok = 1'b0;
        int got = 0;
        res_in = res;
        stream_q.delete();
        if (send_key) for (int i = 0; i < nwords(len); i++) stream_q.push_back(cur_key[i]);
        for (int i = 0; i < NB; i++) stream_q.push_back(cur_blk[i]);
        send_cmd(nk, len);
        send_stream(gaps);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); ok = aes_start; tick();
        end
        if (!ok) check("start_timeout", 32'd0, 32'd1);
        tick(); tick();
        aes_done = 1'b1; tick(); aes_done = 1'b0;
        for (int t = 0; t < 200 && got < NB; t++) begin
            m_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_valid && m_ready) got++;
            tick();
        end
        m_ready = 1'b0;
        if (got != NB) check("out_timeout", got, NB);
    endtask

    task automatic set_words(input logic [31:0] kbase, input logic [31:0] bbase);
        for (int i = 0; i < 8; i++) cur_key[i] = kbase + 32'h04040404 * i;
        for (int i = 0; i < 4; i++) cur_blk[i] = bbase + i;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_new_key = 1'b0; cmd_key_len = 2'd0;
        s_valid = 1'b0; s_data = 32'd0; aes_done = 1'b0; m_ready = 1'b0; res_in = '0;
        set_words(32'h00010203, 32'h000000A0);
        clear_log();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_key_loaded", key_loaded, 0);
        check("reset_busy", busy, 0);
        check("reset_key_len", key_len_o, 0);
        tick();

        // aes_done while idle is ignored.
        aes_done = 1'b1; tick(); aes_done = 1'b0; tick();
        @(negedge clk);
        check("done_idle_busy", busy, 0);
        check("done_idle_mvalid", m_valid, 0);
        tick();

        // 128-bit key, back-to-back words.
        clear_log();
        run_op(1'b1, 2'd0, 1'b1, 1'b0,
               {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDCCBBAA});
        @(negedge clk);
        check("op1_key_loads", n_key_loads, 4);
        check("op1_last_key_addr", last_key_addr, 3);
        check("op1_blk_loads", n_blk_loads, 4);
        check("op1_start_latency", start_cyc - last_blk_cyc, 1);
        check("op1_out_count", out_log.size(), 4);
        check("op1_out_word0", out_log[0], 32'hDDCCBBAA);
        check("op1_out_word3", out_log[3], 32'h11223344);
        check("op1_cmd_ready", cmd_ready, 1);
        check("op1_key_loaded", key_loaded, 1);
        tick();

        // 256-bit key: 12 words with no gaps.
        set_words(32'h10111213, 32'h000000B0);
        clear_log();
        run_op(1'b1, 2'd2, 1'b1, 1'b0, {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4});
        @(negedge clk);
        check("op2_key_loads", n_key_loads, 8);
        check("op2_last_key_addr", last_key_addr, 7);
        check("op2_zero_bubble", last_blk_cyc - first_load_cyc, 11);
        check("op2_key_len", key_len_o, 2);
        tick();

        // Reuse loaded key.
        set_words(32'h20212223, 32'h000000C0);
        clear_log();
        run_op(1'b0, 2'd2, 1'b0, 1'b0, {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10});
        @(negedge clk);
        check("op3_key_loads", n_key_loads, 0);
        check("op3_blk_loads", n_blk_loads, 4);
        check("op3_key_loaded", key_loaded, 1);
        tick();

        // Illegal key length.
        clear_log();
        send_cmd(1'b1, 2'd3);
        tick(); tick();
        @(negedge clk);
        check("ill_err_count", n_errs, 1);
        check("ill_cmd_ready", cmd_ready, 1);
        check("ill_key_loaded", key_loaded, 1);
        check("ill_no_strobes", n_key_loads + n_blk_loads, 0);
        tick();

        // Following valid command: 192-bit key.
        set_words(32'h30313233, 32'h000000D0);
        clear_log();
        run_op(1'b1, 2'd1, 1'b1, 1'b0, {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000});
        @(negedge clk);
        check("op4_key_loads", n_key_loads, 6);
        check("op4_key_len", key_len_o, 1);
        tick();

        // Random input and output stalls.
        for (int r = 0; r < 3; r++) begin
            set_words(32'h40414243 + r, 32'h000000E0 + 32'h10 * r);
            clear_log();
            run_op(1'b1, 2'(r), 1'b1, 1'b1, {32'h0BAD0000 + r, 32'h0BAD1000, 32'h0BAD2000, 32'h0BAD3000});
            @(negedge clk);
            check("gap_key_loads", n_key_loads, nwords(2'(r)));
            check("gap_out_count", out_log.size(), 4);
            tick();
        end

        // Reset in the middle of a key load forces a full reload.
        set_words(32'h50515253, 32'h000000F0);
        clear_log();
        send_cmd(1'b1, 2'd0);
        stream_q.delete();
        stream_q.push_back(cur_key[0]); stream_q.push_back(cur_key[1]);
        send_stream(1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        tick();
        clear_log();
        run_op(1'b0, 2'd0, 1'b1, 1'b0, {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
        @(negedge clk);
        check("rst_reload_key_loads", n_key_loads, 4);
        check("rst_reload_key_loaded", key_loaded, 1);
        check("model_drained", q_key_addr.size() + q_blk_addr.size() + q_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
